// File: rtl/wb_redirect_ctrl_if.sv
// Bundles the writeback/csr trigger inputs, the fetch handshake and the redirect outputs
// of wb_redirect_ctrl. The slave modport is the controller; the master modport is its environment.
interface wb_redirect_ctrl_if;
  logic        ws_ex_i;
  logic        ws_ertn_i;
  logic [31:0] ex_entry_i;
  logic [31:0] era_i;
  logic        inst_req_fire_i;
  logic        inst_resp_fire_i;
  logic        redirect_ready_i;
  logic        flush_o;
  logic        discard_o;
  logic        fetch_stall_o;
  logic        req_block_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  modport slave (
    input  ws_ex_i, ws_ertn_i, ex_entry_i, era_i,
    input  inst_req_fire_i, inst_resp_fire_i, redirect_ready_i,
    output flush_o, discard_o, fetch_stall_o, req_block_o,
    output redirect_valid_o, redirect_pc_o, busy_o
  );

  modport master (
    output ws_ex_i, ws_ertn_i, ex_entry_i, era_i,
    output inst_req_fire_i, inst_resp_fire_i, redirect_ready_i,
    input  flush_o, discard_o, fetch_stall_o, req_block_o,
    input  redirect_valid_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/wb_redirect_ctrl.sv
// Writeback redirect sequencer: flushes the pipeline, waits for stale instruction
// responses to drain, then holds the exception/ERTN target PC until pre-IF takes it.
module wb_redirect_ctrl #(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  wb_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_out_cnt, w_out_cnt_nxt;
  logic [CNT_W-1:0] r_drain_cnt, w_drain_cnt_nxt;
  logic [31:0]      r_target, w_target_nxt;
  logic             r_flush, w_flush_nxt;
  logic             w_trigger;

  assign w_trigger = bus.ws_ex_i | bus.ws_ertn_i;

  // A response with nothing outstanding is ignored rather than wrapping the counter.
  always_comb begin
    w_out_cnt_nxt = r_out_cnt;
    if (bus.inst_req_fire_i && !bus.inst_resp_fire_i)
      w_out_cnt_nxt = r_out_cnt + ONE;
    else if (!bus.inst_req_fire_i && bus.inst_resp_fire_i && (r_out_cnt != '0))
      w_out_cnt_nxt = r_out_cnt - ONE;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_target_nxt    = r_target;
    w_flush_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_flush_nxt     = 1'b1;
          w_target_nxt    = bus.ws_ex_i ? bus.ex_entry_i : bus.era_i;
          w_drain_cnt_nxt = w_out_cnt_nxt;
          w_state_nxt     = (w_out_cnt_nxt != '0) ? S_DRAIN : S_REDIRECT;
        end
      end
      S_DRAIN: begin
        if (bus.inst_resp_fire_i && (r_drain_cnt != '0)) begin
          w_drain_cnt_nxt = r_drain_cnt - ONE;
          if (r_drain_cnt == ONE)
            w_state_nxt = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        if (bus.redirect_ready_i)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_out_cnt   <= '0;
      r_drain_cnt <= '0;
      r_target    <= '0;
      r_flush     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_cnt   <= w_out_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_target    <= w_target_nxt;
      r_flush     <= w_flush_nxt;
    end
  end

  // The flush cycle stalls fetch even when the redirect is already presented.
  assign bus.flush_o          = r_flush;
  assign bus.discard_o        = (r_state == S_DRAIN);
  assign bus.fetch_stall_o    = r_flush | (r_state == S_DRAIN);
  assign bus.req_block_o      = (r_out_cnt == MAX_CNT);
  assign bus.redirect_valid_o = (r_state == S_REDIRECT);
  assign bus.redirect_pc_o    = (r_state == S_REDIRECT) ? r_target : 32'h0;
  assign bus.busy_o           = (r_state != S_IDLE);

endmodule

// File: tb/tb_wb_redirect_ctrl.sv
// Bench for wb_redirect_ctrl: directed vector table, then randomized traffic against
// a reference model that tracks outstanding fetches and pending stale responses.
module tb_wb_redirect_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_redirect_ctrl_if bus();

  wb_redirect_ctrl #(.MAX_OUT(2), .CNT_W(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    bit          rst, ex, ertn, req, resp, rdy;
    logic [31:0] entry, era;
    logic [37:0] exp;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_cnt;
  bit          m_active;
  int          m_stale;
  logic [31:0] m_target;
  bit          m_flush;

  function automatic logic [37:0] E(bit fl, bit di, bit st, bit bl, bit rv, bit bz, logic [31:0] pc);
    return {fl, di, st, bl, rv, bz, pc};
  endfunction

  function automatic logic [37:0] model_exp();
    bit disc, rv;
    disc = m_active && (m_stale > 0);
    rv   = m_active && (m_stale == 0);
    return E(m_flush, disc, m_flush | disc, m_cnt == 2, rv, m_active, rv ? m_target : 32'h0);
  endfunction

  function automatic void model_step(bit rst, bit ex, bit ertn, bit req, bit resp, bit rdy,
                                     logic [31:0] entry, logic [31:0] era);
    int nc;
    bit nf;
    if (rst) begin
      m_cnt = 0; m_active = 0; m_stale = 0; m_target = 0; m_flush = 0;
      return;
    end
    nc = m_cnt + int'(req) - int'(resp);
    if (nc < 0) nc = 0;
    nf = 0;
    if (!m_active) begin
      if (ex || ertn) begin
        m_active = 1;
        m_stale  = nc;
        m_target = ex ? entry : era;
        nf       = 1;
      end
    end else if (m_stale > 0) begin
      if (resp) m_stale = m_stale - 1;
    end else if (rdy) begin
      m_active = 0;
    end
    m_cnt   = nc;
    m_flush = nf;
  endfunction

  task automatic add(input string n, input bit rst, ex, ertn, req, resp, rdy,
                     input logic [31:0] entry, era, input logic [37:0] exp);
    vec_t v;
    v.name = n; v.rst = rst; v.ex = ex; v.ertn = ertn; v.req = req; v.resp = resp;
    v.rdy = rdy; v.entry = entry; v.era = era; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic apply(input bit rst, ex, ertn, req, resp, rdy, input logic [31:0] entry, era);
    reset                = rst;
    bus.ws_ex_i          = ex;
    bus.ws_ertn_i        = ertn;
    bus.inst_req_fire_i  = req;
    bus.inst_resp_fire_i = resp;
    bus.redirect_ready_i = rdy;
    bus.ex_entry_i       = entry;
    bus.era_i            = era;
    @(posedge clk);
    model_step(rst, ex, ertn, req, resp, rdy, entry, era);
    #1;
  endtask

  task automatic check(input string n, input logic [37:0] exp);
    logic [37:0] act;
    act = {bus.flush_o, bus.discard_o, bus.fetch_stall_o, bus.req_block_o,
           bus.redirect_valid_o, bus.busy_o, bus.redirect_pc_o};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {fl,di,st,bl,rv,bz,pc}=%h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  initial begin
    bit rst, ex, ertn, req, resp, rdy, trig;
    logic [31:0] entry, era;
    logic [37:0] z;
    z = E(0, 0, 0, 0, 0, 0, 0);

    add("reset",       1, 0, 0, 0, 0, 0, 0, 0, z);
    add("tp1_trig",    0, 1, 0, 0, 0, 0, 32'h1C008000, 0, E(1, 0, 1, 0, 1, 1, 32'h1C008000));
    add("tp1_hold0",   0, 0, 0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 1, 1, 32'h1C008000));
    add("tp1_hold1",   0, 0, 0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 1, 1, 32'h1C008000));
    add("tp1_hold2",   0, 0, 0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 1, 1, 32'h1C008000));
    add("tp1_accept",  0, 0, 0, 0, 0, 1, 0, 0, z);
    add("tp2_req1",    0, 0, 0, 1, 0, 0, 0, 0, z);
    add("tp2_req2",    0, 0, 0, 1, 0, 0, 0, 0, E(0, 0, 0, 1, 0, 0, 0));
    add("tp2_ertn",    0, 0, 1, 0, 0, 0, 0, 32'h1C000100, E(1, 1, 1, 1, 0, 1, 0));
    add("tp2_resp1",   0, 0, 0, 0, 1, 0, 0, 0, E(0, 1, 1, 0, 0, 1, 0));
    add("tp2_resp2",   0, 0, 0, 0, 1, 0, 0, 0, E(0, 0, 0, 0, 1, 1, 32'h1C000100));
    add("tp2_accept",  0, 0, 0, 0, 0, 1, 0, 0, z);
    add("tp3_req",     0, 0, 0, 1, 0, 0, 0, 0, z);
    add("tp3_trig_rq", 0, 1, 0, 1, 0, 0, 32'h100, 0, E(1, 1, 1, 1, 0, 1, 0));
    add("tp3_resp1",   0, 0, 0, 0, 1, 0, 0, 0, E(0, 1, 1, 0, 0, 1, 0));
    add("tp3_resp2",   0, 0, 0, 0, 1, 0, 0, 0, E(0, 0, 0, 0, 1, 1, 32'h100));
    add("tp3_accept",  0, 0, 0, 0, 0, 1, 0, 0, z);
    add("tp3_req_b",   0, 0, 0, 1, 0, 0, 0, 0, z);
    add("tp3_trig_rs", 0, 1, 0, 0, 1, 0, 32'h200, 0, E(1, 0, 1, 0, 1, 1, 32'h200));
    add("tp3_acc_b",   0, 0, 0, 0, 0, 1, 0, 0, z);
    add("tp4_both",    0, 1, 1, 0, 0, 0, 32'hA, 32'hB, E(1, 0, 1, 0, 1, 1, 32'hA));
    add("tp4_accept",  0, 0, 0, 0, 0, 1, 0, 0, z);
    add("tp5_req1",    0, 0, 0, 1, 0, 0, 0, 0, z);
    add("tp5_req2",    0, 0, 0, 1, 0, 0, 0, 0, E(0, 0, 0, 1, 0, 0, 0));
    add("tp5_resp",    0, 0, 0, 0, 1, 0, 0, 0, z);
    add("tp5_both",    0, 0, 0, 1, 1, 0, 0, 0, z);
    add("tp5_req3",    0, 0, 0, 1, 0, 0, 0, 0, E(0, 0, 0, 1, 0, 0, 0));
    add("tp5_resp_a",  0, 0, 0, 0, 1, 0, 0, 0, z);
    add("tp5_resp_b",  0, 0, 0, 0, 1, 0, 0, 0, z);
    add("tp6_req1",    0, 0, 0, 1, 0, 0, 0, 0, z);
    add("tp6_req2",    0, 0, 0, 1, 0, 0, 0, 0, E(0, 0, 0, 1, 0, 0, 0));
    add("tp6_trig",    0, 1, 0, 0, 0, 0, 32'h300, 0, E(1, 1, 1, 1, 0, 1, 0));
    add("tp6_resp",    0, 0, 0, 0, 1, 0, 0, 0, E(0, 1, 1, 0, 0, 1, 0));
    add("tp6_reset",   1, 0, 0, 0, 0, 0, 0, 0, z);
    add("tp6_stray",   0, 0, 0, 0, 1, 0, 0, 0, z);
    add("tp6_req_a",   0, 0, 0, 1, 0, 0, 0, 0, z);
    add("tp6_req_b",   0, 0, 0, 1, 0, 0, 0, 0, E(0, 0, 0, 1, 0, 0, 0));
    add("tp6_resp_a",  0, 0, 0, 0, 1, 0, 0, 0, z);
    add("tp6_resp_b",  0, 0, 0, 0, 1, 0, 0, 0, z);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].ex, tbl[i].ertn, tbl[i].req, tbl[i].resp, tbl[i].rdy,
            tbl[i].entry, tbl[i].era);
      check(tbl[i].name, tbl[i].exp);
    end

    for (int n = 0; n < 2000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      req   = (m_cnt < 2) && ($urandom_range(0, 1) == 1);
      resp  = (m_cnt > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      trig  = !m_active && ($urandom_range(0, 5) == 0);
      ex    = trig && ($urandom_range(0, 1) == 1);
      ertn  = trig && (!ex || ($urandom_range(0, 1) == 1));
      rdy   = ($urandom_range(0, 2) != 0);
      entry = $urandom;
      era   = $urandom;
      apply(rst, ex, ertn, req, resp, rdy, entry, era);
      check("random", model_exp());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
